// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the APB GPIO port.
// Holds the register word addresses, the register count and the common reset value.
// The helper function decides whether a word address hits a mapped register.
package gpio_pkg;

    localparam int unsigned ADDR_DATA_OUT = 0;
    localparam int unsigned ADDR_DIR      = 1;
    localparam int unsigned ADDR_DATA_IN  = 2;
    localparam int unsigned ADDR_IRQ_EN   = 3;
    localparam int unsigned ADDR_IRQ_EDGE = 4;
    localparam int unsigned ADDR_IRQ_STAT = 5;

    localparam int unsigned NUM_REGS = 6;

    // Every register, synchroniser stage and output flop resets to this value.
    localparam logic [31:0] REG_RESET = 32'h0;

    function automatic logic addr_mapped(input logic [31:0] addr);
        return addr < NUM_REGS;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-wide, STAGES-deep flop chain that brings asynchronous pad inputs into clk.
// Ports: clk/rst (async active-high), d_i raw pad values, q_o synchronised values.
// Latency: STAGES rising edges from a d_i change to q_o; no flow control.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    localparam logic [WIDTH-1:0] RST_VAL = REG_RESET[WIDTH-1:0];

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/apb_gpio_port.sv
// apb_gpio_port: APB slave GPIO with direction control, synchronised inputs and edge interrupts.
// Ports: APB3 slave (PCLK, PRESET, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR),
//        pads (pin_in, pin_out, pin_oe) and a level interrupt irq. Zero wait states.
module apb_gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [WIDTH-1:0]  PWDATA,
    output logic [WIDTH-1:0]  PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [WIDTH-1:0]  pin_in,
    output logic [WIDTH-1:0]  pin_out,
    output logic [WIDTH-1:0]  pin_oe,
    output logic              irq
);

    localparam logic [WIDTH-1:0] RST_VAL = REG_RESET[WIDTH-1:0];

    // Register file and APB output flops
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] rdata_mux;
    logic [WIDTH-1:0] event_bits;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0]      addr_ext;
    logic             setup;
    logic             access;
    logic             is_err;
    logic             wr_en;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (PCLK),
        .rst (PRESET),
        .d_i (pin_in),
        .q_o (data_in)
    );

    assign addr_ext = 32'(PADDR);
    assign setup    = PSEL & ~PENABLE;
    // pready_q is only ever set by a setup cycle, so it doubles as the
    // "setup was seen" qualifier: a bare PENABLE cannot commit anything.
    assign access   = PSEL & PENABLE & pready_q;
    assign is_err   = ~addr_mapped(addr_ext) | (PWRITE & (addr_ext == ADDR_DATA_IN));
    assign wr_en    = access & PWRITE & ~is_err;

    always_comb begin
        rdata_mux = '0;
        case (addr_ext)
            ADDR_DATA_OUT: rdata_mux = dout_q;
            ADDR_DIR:      rdata_mux = dir_q;
            ADDR_DATA_IN:  rdata_mux = data_in;
            ADDR_IRQ_EN:   rdata_mux = en_q;
            ADDR_IRQ_EDGE: rdata_mux = edge_q;
            ADDR_IRQ_STAT: rdata_mux = stat_q;
            default:       rdata_mux = '0;
        endcase
    end

    // Per-bit edge select: rising where edge_q=1, falling where edge_q=0.
    // Output pins are masked so driving a pad never raises an interrupt.
    assign event_bits = ((edge_q & data_in & ~prev_q) | (~edge_q & ~data_in & prev_q)) & ~dir_q;

    assign w1c_mask = (wr_en && addr_ext == ADDR_IRQ_STAT) ? PWDATA : '0;

    always_comb begin
        dout_d    = dout_q;
        dir_d     = dir_q;
        en_d      = en_q;
        edge_d    = edge_q;
        prdata_d  = prdata_q;
        if (wr_en) begin
            case (addr_ext)
                ADDR_DATA_OUT: dout_d = PWDATA;
                ADDR_DIR:      dir_d  = PWDATA;
                ADDR_IRQ_EN:   en_d   = PWDATA;
                ADDR_IRQ_EDGE: edge_d = PWDATA;
                default:       ;
            endcase
        end
        if (setup && !PWRITE) begin
            prdata_d = rdata_mux;
        end
        // Event OR-ed after the clear so a same-cycle set wins.
        stat_d    = (stat_q & ~w1c_mask) | event_bits;
        pready_d  = setup;
        pslverr_d = setup & is_err;
        irq_d     = |(stat_q & en_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            dout_q    <= RST_VAL;
            dir_q     <= RST_VAL;
            en_q      <= RST_VAL;
            edge_q    <= RST_VAL;
            stat_q    <= RST_VAL;
            prev_q    <= RST_VAL;
            prdata_q  <= RST_VAL;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            en_q      <= en_d;
            edge_q    <= edge_d;
            stat_q    <= stat_d;
            prev_q    <= data_in;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign pin_out = dout_q;
    assign pin_oe  = dir_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_apb_gpio_port.sv
// tb_apb_gpio_port: directed and randomized APB traffic against a behavioural model of the GPIO port.
// The model recomputes every registered output at each clock edge; a negedge process compares them.
// Directed sequences pin the model with hand-computed literal expectations.
module tb_apb_gpio_port;

    localparam int S = 2;

    logic       PCLK;
    logic       PRESET;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] pin_in;
    logic [7:0] pin_out;
    logic [7:0] pin_oe;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    apb_gpio_port #(.WIDTH(8), .ADDR_W(8), .SYNC_STAGES(S)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_dout, m_dir, m_en, m_edge, m_stat, m_prdata;
    logic       m_pready, m_pslverr, m_irq;
    logic [7:0] m_hist [0:S];   // m_hist[0] = pin at last edge; DATA_IN = m_hist[S-1]
    logic [7:0] m_din, m_prv, m_ev, m_nstat, m_rd;
    logic       m_setup, m_access, m_err;
    int unsigned m_addr;

    function automatic logic [7:0] model_read(input int unsigned a, input logic [7:0] din);
        case (a)
            0: return m_dout;
            1: return m_dir;
            2: return din;
            3: return m_en;
            4: return m_edge;
            5: return m_stat;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_dout = 0; m_dir = 0; m_en = 0; m_edge = 0; m_stat = 0; m_prdata = 0;
            m_pready = 0; m_pslverr = 0; m_irq = 0;
            for (int k = 0; k <= S; k++) m_hist[k] = 0;
        end else begin
            m_din    = m_hist[S-1];
            m_prv    = m_hist[S];
            m_addr   = int'(PADDR);
            m_setup  = PSEL && !PENABLE;
            m_access = PSEL && PENABLE && m_pready;
            m_err    = (m_addr > 5) || (PWRITE && m_addr == 2);
            // A bit fires when it changed and its new level matches the selected polarity.
            m_ev = 0;
            for (int b = 0; b < 8; b++)
                if (!m_dir[b] && m_din[b] != m_prv[b] && m_din[b] == m_edge[b]) m_ev[b] = 1'b1;
            m_nstat = m_stat;
            if (m_access && PWRITE && m_addr == 5) m_nstat = m_nstat & ~PWDATA;
            m_nstat = m_nstat | m_ev;
            m_rd = model_read(m_addr, m_din);
            m_irq = (m_stat & m_en) != 0;
            if (m_access && PWRITE && !m_err) begin
                if (m_addr == 0) m_dout = PWDATA;
                if (m_addr == 1) m_dir  = PWDATA;
                if (m_addr == 3) m_en   = PWDATA;
                if (m_addr == 4) m_edge = PWDATA;
            end
            m_stat = m_nstat;
            if (m_setup && !PWRITE) m_prdata = m_rd;
            m_pready  = m_setup;
            m_pslverr = m_setup && m_err;
            for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pin_in;
        end
    end

    always @(negedge PCLK) begin
        if (chk_en && !PRESET) begin
            chk("cmp_prdata", PRDATA, m_prdata);
            chk("cmp_pready", PREADY, m_pready);
            chk("cmp_pslverr", PSLVERR, m_pslverr);
            chk("cmp_pin_out", pin_out, m_dout);
            chk("cmp_pin_oe", pin_oe, m_dir);
            chk("cmp_irq", irq, m_irq);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output logic err);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        PENABLE = 1;
        chk("pready_access", PREADY, 1);
        rdata = PRDATA;
        err   = PSLVERR;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0;
        chk("pready_one_cycle", PREADY, 0);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] wdata, input logic exp_err);
        logic [7:0] rd;
        logic e;
        xfer(1'b1, addr, wdata, rd, e);
        chk("wr_pslverr", e, exp_err);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp,
                          input logic exp_err);
        logic [7:0] rd;
        logic e;
        xfer(1'b0, addr, 8'h00, rd, e);
        chk(name, rd, exp);
        chk({name, "_err"}, e, exp_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge PCLK);
    endtask

    initial begin
        int cnt;
        logic [7:0] rd;
        logic e;
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; pin_in = 0;
        idle(3);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pready", PREADY, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_pin_oe", pin_oe, 0);
        chk("rst_pin_out", pin_out, 0);
        chk("rst_irq", irq, 0);
        PRESET = 0;
        chk_en = 1;

        // Reset values of all six registers
        for (int a = 0; a < 6; a++) rd_chk("rst_reg", 8'(a), 8'h00, 1'b0);

        // Outputs and read-back of the pad
        wr(8'h01, 8'hFF, 1'b0);
        chk("dir_pin_oe", pin_oe, 8'hFF);
        wr(8'h00, 8'hA5, 1'b0);
        chk("dout_pin_out", pin_out, 8'hA5);
        pin_in = 8'hA5;
        idle(S + 1);
        rd_chk("data_in_rb", 8'h02, 8'hA5, 1'b0);
        pin_in = 8'h00;
        idle(S + 2);

        // Edge interrupts: bits 3:0 rising, 7:4 falling
        wr(8'h01, 8'h00, 1'b0);
        wr(8'h04, 8'h0F, 1'b0);
        wr(8'h03, 8'hFF, 1'b0);
        idle(2);
        chk("irq_quiet", irq, 0);
        pin_in = 8'hFF;
        cnt = 0;
        while (!irq && cnt < 10) begin
            @(negedge PCLK);
            cnt++;
        end
        chk("irq_latency", cnt, S + 2);
        idle(2);
        pin_in = 8'h00;
        idle(S + 3);
        rd_chk("stat_all", 8'h05, 8'hFF, 1'b0);

        // W1C partial then full clear
        wr(8'h05, 8'h0F, 1'b0);
        rd_chk("stat_w1c_lo", 8'h05, 8'hF0, 1'b0);
        chk("irq_still", irq, 1);
        wr(8'h05, 8'hF0, 1'b0);
        chk("irq_lag", irq, 1);
        @(negedge PCLK);
        chk("irq_drop", irq, 0);
        rd_chk("stat_clear", 8'h05, 8'h00, 1'b0);

        // Rising event on bit 0 lands on the same edge as a W1C of bit 0
        @(negedge PCLK);
        pin_in = 8'h01;
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h05; PWDATA = 8'h01;
        @(negedge PCLK);
        PENABLE = 1;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0;
        rd_chk("stat_set_wins", 8'h05, 8'h01, 1'b0);

        // Error responses
        wr(8'h02, 8'hFF, 1'b1);
        rd_chk("bad_rd", 8'h07, 8'h00, 1'b1);
        rd_chk("dir_unchg", 8'h01, 8'h00, 1'b0);
        rd_chk("dout_unchg", 8'h00, 8'hA5, 1'b0);
        rd_chk("din_unchg", 8'h02, 8'h01, 1'b0);

        // Randomized traffic; the compare process does the checking
        for (int it = 0; it < 400; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) pin_in = 8'($urandom);
            if (kind == 0) begin
                idle(int'($urandom_range(1, 4)));
            end else if (kind == 1) begin
                @(negedge PCLK);
                PSEL = 1; PENABLE = 1; PWRITE = 1'($urandom);
                PADDR = 8'($urandom_range(0, 7)); PWDATA = 8'($urandom);
                @(negedge PCLK);
                PSEL = 0; PENABLE = 0;
            end else begin
                xfer(1'($urandom), 8'($urandom_range(0, 8)), 8'($urandom), rd, e);
            end
        end
        idle(4);

        // Reset during an access cycle
        wr(8'h01, 8'h3C, 1'b0);
        wr(8'h00, 8'hA5, 1'b0);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h00;
        @(negedge PCLK);
        PENABLE = 1;
        chk("pre_rst_prdata", PRDATA, 8'hA5);
        chk("pre_rst_pin_oe", pin_oe, 8'h3C);
        #2 PRESET = 1;
        #1;
        chk("mid_rst_prdata", PRDATA, 0);
        chk("mid_rst_pready", PREADY, 0);
        chk("mid_rst_pslverr", PSLVERR, 0);
        chk("mid_rst_pin_out", pin_out, 0);
        chk("mid_rst_pin_oe", pin_oe, 0);
        chk("mid_rst_irq", irq, 0);
        @(negedge PCLK);
        PRESET = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("no_pready_after_rst", PREADY, 0);
        end
        PSEL = 0; PENABLE = 0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
